// File: rtl/tiny_nn_result_collector.sv
// tiny_nn_result_collector
// Snoops the command/data stream going into tiny_nn_top and that block's
// 8-bit data_o. It runs a mirror of the tiny_nn_top sequencer so that it
// knows which data_o bytes are convolve results. Each low/high byte pair is
// reassembled into one 16-bit fp_t word and queued in a small
// first-word-fall-through FIFO for a valid/ready consumer.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   nn_data_i       word driven on tiny_nn_top data_i
//   nn_data_o_i     tiny_nn_top data_o
//   result_o        {high,low} result at the FIFO head (0 when empty)
//   result_last_o   head entry is the final result of its command
//   result_valid_o  FIFO non-empty
//   result_ready_i  consumer takes the head when valid & ready
//   busy_o          mirror sequencer not in Idle
//   overflow_o      sticky: a completed result was dropped (cleared by the
//                   next convolve command)
module tiny_nn_result_collector #(
  parameter int         CountWidth    = 12,
  parameter int         ParamWords    = 8,
  parameter int         FifoDepth     = 4,
  parameter logic [3:0] CmdOpConvolve = 4'h1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] nn_data_i,
  input  logic [7:0]  nn_data_o_i,
  output logic [15:0] result_o,
  output logic        result_last_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int PcW  = (ParamWords > 1) ? $clog2(ParamWords) : 1;

  typedef enum logic [1:0] {
    Idle,
    ParamIn,
    Exec
  } state_t;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } entry_t;

  state_t                state;
  logic [CountWidth-1:0] count;
  logic [PcW-1:0]        param_cnt;
  logic                  phase;
  logic [7:0]            low_byte;

  entry_t                mem [FifoDepth];
  logic [PtrW:0]         wr_ptr;
  logic [PtrW:0]         rd_ptr;

  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  drop;
  entry_t                push_entry;

  // The high byte arrives on the phase-1 cycle; it is combined with the low
  // byte captured one cycle earlier and written straight into the FIFO.
  assign push       = (state == Exec) && phase;
  assign push_entry = '{last: (count == '0), data: {nn_data_o_i, low_byte}};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = ((wr_ptr - rd_ptr) == (PtrW + 1)'(FifoDepth));
  assign pop    = !empty && result_ready_i;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= Idle;
      count      <= '0;
      param_cnt  <= '0;
      phase      <= 1'b0;
      low_byte   <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (nn_data_i[15:12] == CmdOpConvolve) begin
            count      <= nn_data_i[CountWidth-1:0];
            param_cnt  <= '0;
            overflow_o <= 1'b0;
            state      <= ParamIn;
          end
        end
        ParamIn: begin
          if (param_cnt == PcW'(ParamWords - 1)) begin
            phase <= 1'b0;
            state <= Exec;
          end else begin
            param_cnt <= param_cnt + 1'b1;
          end
        end
        Exec: begin
          phase <= ~phase;
          if (!phase) begin
            low_byte <= nn_data_o_i;
          end else if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and the outputs are gated while empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr[PtrW-1:0]] <= push_entry;
    end
  end

  assign result_valid_o = !empty;
  assign result_o       = empty ? 16'h0000 : mem[rd_ptr[PtrW-1:0]].data;
  assign result_last_o  = empty ? 1'b0 : mem[rd_ptr[PtrW-1:0]].last;
  assign busy_o         = (state != Idle);

endmodule
